// File: rtl/lc3b_alu_iter_pkg.sv
// Shared LC-3b ALU definitions: the op code enum and the iterative ALU state enum.
package lc3b_alu_iter_pkg;

    typedef enum logic [3:0] {
        alu_add  = 4'd0,
        alu_and  = 4'd1,
        alu_not  = 4'd2,
        alu_pass = 4'd3,
        alu_sll  = 4'd4,
        alu_srl  = 4'd5,
        alu_sra  = 4'd6,
        alu_mul  = 4'd7,
        alu_divu = 4'd8
    } lc3b_aluop;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIN  = 2'd2
    } alu_iter_state;

endpackage

// File: rtl/lc3b_alu_iter_muldiv_core.sv
// Shift/accumulate datapath shared by unsigned multiply and restoring divide.
// {acc,q} is one double-width shift register: for multiply acc collects the
// high product while the multiplier drains out of q; for divide acc is the
// partial remainder and q shifts the dividend out and the quotient in.
// Step results are exported combinationally so the caller can latch the
// final answer on the same edge as the last step.
module lc3b_muldiv_core
    import lc3b_alu_iter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] lo_nxt_o,
    output logic [WIDTH-1:0] hi_nxt_o
);

    localparam int             LASTI = WIDTH - 1;
    localparam logic [SHW:0]   LAST  = LASTI[SHW:0];
    localparam logic [SHW:0]   ONE   = {{SHW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] acc_q, q_q, m_q;
    logic             div_q;
    logic [SHW:0]     cnt_q;

    logic [WIDTH-1:0] acc_d, q_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_dif;

    assign last_o   = (cnt_q == LAST);
    assign lo_nxt_o = q_d;
    assign hi_nxt_o = acc_d;

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
        div_sh  = {acc_q, q_q[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, m_q});
        // When div_ge holds the true difference is below m_q, so WIDTH bits suffice.
        div_dif = div_sh[WIDTH-1:0] - m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        if (div_q) begin
            acc_d = div_ge ? div_dif : div_sh[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], div_ge};
        end else begin
            acc_d = mul_sum[WIDTH:1];
            q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
        end
    end

    // Operand load on an accepted start, then one step per BUSY cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            q_q   <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            acc_q <= '0;
            q_q   <= div_i ? a_i : b_i;
            m_q   <= div_i ? b_i : a_i;
            div_q <= div_i;
            cnt_q <= '0;
        end else if (step_i) begin
            acc_q <= acc_d;
            q_q   <= q_d;
            if (!last_o)
                cnt_q <= cnt_q + ONE;
        end
    end

endmodule

// File: rtl/lc3b_alu_iter.sv
// Multi-cycle LC-3b ALU: single-cycle logic/shift ops plus iterative unsigned
// multiply and divide behind a start/ready/done handshake.
module lc3b_alu_iter
    import lc3b_alu_iter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] hi,
    output logic             dbz
);

    alu_iter_state    state_q;
    logic             done_q, dbz_q;
    logic [WIDTH-1:0] f_q, hi_q;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_f;
    logic             div_zero, iter_op, core_load;
    logic             core_last;
    logic [WIDTH-1:0] core_lo, core_hi;

    assign shamt     = b[SHW-1:0];
    assign div_zero  = (aluop == alu_divu) && (b == '0);
    assign iter_op   = (aluop == alu_mul) || ((aluop == alu_divu) && (b != '0));
    assign core_load = start && (state_q == IDLE) && iter_op;

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign f     = f_q;
    assign hi    = hi_q;
    assign dbz   = dbz_q;

    // Single-cycle result mux; multiply/divide and undefined codes give zero here.
    always_comb begin
        sc_f = '0;
        case (aluop)
            alu_add:  sc_f = a + b;
            alu_and:  sc_f = a & b;
            alu_not:  sc_f = ~a;
            alu_pass: sc_f = a;
            alu_sll:  sc_f = a << shamt;
            alu_srl:  sc_f = a >> shamt;
            alu_sra:  sc_f = $signed(a) >>> shamt;
            default:  sc_f = '0;
        endcase
    end

    lc3b_muldiv_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load_i   (core_load),
        .step_i   (state_q == BUSY),
        .div_i    (aluop == alu_divu),
        .a_i      (a),
        .b_i      (b),
        .last_o   (core_last),
        .lo_nxt_o (core_lo),
        .hi_nxt_o (core_hi)
    );

    // Control FSM; results are written only on entry to FIN and held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            f_q     <= '0;
            hi_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (iter_op) begin
                            state_q <= BUSY;
                        end else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            f_q     <= div_zero ? '1 : sc_f;
                            hi_q    <= div_zero ? a : '0;
                            dbz_q   <= div_zero;
                        end
                    end
                end
                BUSY: begin
                    if (core_last) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                        f_q     <= core_lo;
                        hi_q    <= core_hi;
                        dbz_q   <= 1'b0;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
